// File: rtl/wb_pkg.sv
// Shared types for the Wishbone stream writer.
//   wb_state_t : controller states (IDLE, REQ, BACKOFF)
//   wb_fault_t : 2-bit fault code reported on fault_code_o
//   RETRY_W    : width of the retry counter (MAX_RETRIES range 0-15)
//   TIMER_W    : width of the watchdog counter (TIMEOUT range 1-255)
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_REQ     = 2'd1,
        ST_BACKOFF = 2'd2
    } wb_state_t;

    typedef enum logic [1:0] {
        FAULT_NONE    = 2'd0,
        FAULT_ERR     = 2'd1,
        FAULT_RETRY   = 2'd2,
        FAULT_TIMEOUT = 2'd3
    } wb_fault_t;

    localparam int RETRY_W = 4;
    localparam int TIMER_W = 8;

endpackage

// File: rtl/wb_watchdog.sv
// Response watchdog for the Wishbone stream writer.
//   clk_i, rst_i : clock, asynchronous active-high reset
//   load_i       : hold the count at zero (asserted whenever outside REQ)
//   count_i      : advance the count (asserted in REQ)
//   expired_o    : the current cycle is the TIMEOUT-th counted cycle
module wb_watchdog
    import wb_pkg::*;
#(
    parameter int TIMEOUT = 15
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic count_i,
    output logic expired_o
);

    localparam logic [TIMER_W-1:0] LAST = TIMER_W'(TIMEOUT - 1);

    logic [TIMER_W-1:0] count_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            count_q <= '0;
        else if (load_i)
            count_q <= '0;
        else if (count_i && count_q != LAST)
            count_q <= count_q + 1'b1;
    end

    // count_q holds (cycles already spent in REQ), so the TIMEOUT-th cycle sees LAST.
    assign expired_o = count_i && (count_q == LAST);

endmodule

// File: rtl/wb_stream_writer.sv
// Valid/ready byte stream to single Wishbone classic write cycles.
//   clk_i, rst_i                 : clock, asynchronous active-high reset
//   s_valid_i/s_ready_o/s_data_i : input stream, one word per write cycle
//   cyc_o/stb_o/we_o/dat_o       : Wishbone controller outputs (all registered)
//   ack_i/err_i/rty_i/dat_i      : Wishbone responses (dat_i unused)
//   fault_o/fault_code_o         : sticky fault flag and last fault code
//   fault_clr_i                  : synchronous fault clear (a new fault wins)
// Optional: define WB_TIMEOUT_EN to abort REQ after TIMEOUT silent cycles.
module wb_stream_writer
    import wb_pkg::*;
#(
    parameter int DAT_WIDTH   = 8,
    parameter int MAX_RETRIES = 3,
    parameter int TIMEOUT     = 15
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 s_valid_i,
    output logic                 s_ready_o,
    input  logic [DAT_WIDTH-1:0] s_data_i,
    output logic                 cyc_o,
    output logic                 stb_o,
    output logic                 we_o,
    output logic [DAT_WIDTH-1:0] dat_o,
    input  logic                 ack_i,
    input  logic                 err_i,
    input  logic                 rty_i,
    input  logic [DAT_WIDTH-1:0] dat_i,
    output logic                 fault_o,
    output logic [1:0]           fault_code_o,
    input  logic                 fault_clr_i
);

    localparam logic [RETRY_W-1:0] MAX_R = RETRY_W'(MAX_RETRIES);

    wb_state_t            state_q, state_d;
    logic [DAT_WIDTH-1:0] hold_q;
    logic [RETRY_W-1:0]   retry_q;
    wb_fault_t            code_q, new_code;
    logic                 accept, retry_inc, rec_fault, expired;

    wire unused_dat = ^dat_i;

`ifdef WB_TIMEOUT_EN
    wb_watchdog #(.TIMEOUT(TIMEOUT)) u_watchdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (state_q != ST_REQ),
        .count_i   (state_q == ST_REQ),
        .expired_o (expired)
    );
`else
    assign expired = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        retry_inc = 1'b0;
        rec_fault = 1'b0;
        new_code  = FAULT_NONE;
        case (state_q)
            ST_IDLE: begin
                if (s_valid_i) begin
                    accept  = 1'b1;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                // err > ack > rty; the timeout only fires when the device stayed silent.
                if (err_i) begin
                    state_d   = ST_IDLE;
                    rec_fault = 1'b1;
                    new_code  = FAULT_ERR;
                end else if (ack_i) begin
                    state_d = ST_IDLE;
                end else if (rty_i) begin
                    if (retry_q < MAX_R) begin
                        retry_inc = 1'b1;
                        state_d   = ST_BACKOFF;
                    end else begin
                        state_d   = ST_IDLE;
                        rec_fault = 1'b1;
                        new_code  = FAULT_RETRY;
                    end
                end else if (expired) begin
                    state_d   = ST_IDLE;
                    rec_fault = 1'b1;
                    new_code  = FAULT_TIMEOUT;
                end
            end
            ST_BACKOFF: state_d = ST_REQ;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            hold_q    <= '0;
            retry_q   <= '0;
            cyc_o     <= 1'b0;
            stb_o     <= 1'b0;
            we_o      <= 1'b0;
            s_ready_o <= 1'b1;
            fault_o   <= 1'b0;
            code_q    <= FAULT_NONE;
        end else begin
            state_q <= state_d;
            if (accept) begin
                hold_q  <= s_data_i;
                retry_q <= '0;
            end else if (retry_inc) begin
                retry_q <= retry_q + 1'b1;
            end
            // Outputs are registered from the next state so no response input
            // reaches a port combinationally.
            cyc_o     <= (state_d == ST_REQ);
            stb_o     <= (state_d == ST_REQ);
            we_o      <= (state_d == ST_REQ);
            s_ready_o <= (state_d == ST_IDLE);
            if (rec_fault) begin
                fault_o <= 1'b1;
                code_q  <= new_code;
            end else if (fault_clr_i) begin
                fault_o <= 1'b0;
                code_q  <= FAULT_NONE;
            end
        end
    end

    assign dat_o        = hold_q;
    assign fault_code_o = code_q;

endmodule

// File: tb/tb_wb_stream_writer.sv
// Randomized self-checking bench for wb_stream_writer.
// The device side is driven per word from a response plan; expected bus
// behaviour and the fault register are derived from the write/retry rules.
module tb_wb_stream_writer;

    localparam int DW   = 8;
    localparam int MAXR = 3;
    localparam int TMO  = 15;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [DW-1:0] s_data = '0;
    logic          cyc, stb, we;
    logic [DW-1:0] dat_o;
    logic          ack = 1'b0, err = 1'b0, rty = 1'b0;
    logic [DW-1:0] dat_i = '0;
    logic          fault;
    logic [1:0]    fault_code;
    logic          fault_clr = 1'b0;

    wb_stream_writer #(.DAT_WIDTH(DW), .MAX_RETRIES(MAXR), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst),
        .s_valid_i(s_valid), .s_ready_o(s_ready), .s_data_i(s_data),
        .cyc_o(cyc), .stb_o(stb), .we_o(we), .dat_o(dat_o),
        .ack_i(ack), .err_i(err), .rty_i(rty), .dat_i(dat_i),
        .fault_o(fault), .fault_code_o(fault_code), .fault_clr_i(fault_clr)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int clk_cnt = 0;
    always @(posedge clk) clk_cnt++;

    // reference fault register
    logic       exp_fault = 1'b0;
    logic [1:0] exp_code  = 2'd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_req(input logic [DW-1:0] d);
        check("req_cyc", cyc, 1);
        check("req_stb", stb, 1);
        check("req_we", we, 1);
        check("req_dat", dat_o, d);
        check("req_ready", s_ready, 0);
    endtask

    task automatic check_fault();
        check("fault_o", fault, exp_fault);
        check("fault_code", fault_code, exp_code);
    endtask

    // One word. Attempt a waits waits[2a+:2] silent cycles, then answers with
    // {err,ack,rty} = resps[3a+:3]. clr pulses fault_clr with the final answer.
    task automatic run_word(input logic [DW-1:0] d, input logic [14:0] resps,
                            input logic [9:0] waits, input logic clr, input logic noise);
        logic [2:0] r;
        int tries;
        logic done, new_f;
        logic [1:0] new_c;
        check("idle_ready", s_ready, 1);
        check("idle_cyc", cyc, 0);
        s_valid = 1'b1;
        s_data  = d;
        if (noise) {err, ack, rty} = 3'($urandom_range(0, 7));
        @(negedge clk);
        s_valid = 1'b0;
        s_data  = DW'($urandom);
        {err, ack, rty} = 3'b000;
        tries = 0;
        done  = 1'b0;
        for (int a = 0; a < 5 && !done; a++) begin
            for (int w = 0; w < int'(waits[2*a +: 2]); w++) begin
                check_req(d);
                @(negedge clk);
            end
            check_req(d);
            r = resps[3*a +: 3];
            new_f = 1'b0;
            new_c = 2'd0;
            done  = 1'b1;
            if (r[2]) begin
                new_f = 1'b1; new_c = 2'd1;
            end else if (r[1]) begin
                new_f = 1'b0;
            end else if (tries < MAXR) begin
                done = 1'b0;
            end else begin
                new_f = 1'b1; new_c = 2'd2;
            end
            {err, ack, rty} = r;
            fault_clr = clr && done;
            @(negedge clk);
            {err, ack, rty} = 3'b000;
            check("resp_cyc_low", cyc, 0);
            if (new_f) begin
                exp_fault = 1'b1; exp_code = new_c;
            end else if (fault_clr) begin
                exp_fault = 1'b0; exp_code = 2'd0;
            end
            fault_clr = 1'b0;
            if (!done) begin
                check("backoff_ready", s_ready, 0);
                if (noise) {err, ack, rty} = 3'($urandom_range(0, 7));
                tries++;
                @(negedge clk);
                {err, ack, rty} = 3'b000;
            end else begin
                check("post_ready", s_ready, 1);
                check_fault();
            end
        end
        if (!done) check("attempt_bound", 0, 1);
    endtask

    initial begin
        int t0, n;
        logic [14:0] rp;
        logic [9:0]  wp;

        // reset state
        @(negedge clk);
        check("rst_ready", s_ready, 1);
        check("rst_cyc", cyc, 0);
        check("rst_stb", stb, 0);
        check("rst_we", we, 0);
        check("rst_dat", dat_o, 0);
        check_fault();
        rst = 1'b0;
        @(negedge clk);

        // 0xA5 acked in the third REQ cycle
        run_word(8'hA5, 15'b000_000_000_000_010, 10'b00_00_00_00_10, 1'b0, 1'b0);

        // zero-wait device: one word every two clocks, data in order
        for (int i = 1; i <= 4; i++) begin
            t0 = clk_cnt;
            run_word(8'(i), 15'b010, 10'b0, 1'b0, 1'b0);
            check("throughput", clk_cnt - t0, 2);
        end

        // three retries then ack: no fault
        run_word(8'h3C, 15'b000_010_001_001_001, 10'b00_00_01_00_01, 1'b0, 1'b0);
        check_fault();
        // four retries: retries exhausted
        run_word(8'h5A, 15'b000_001_001_001_001, 10'b0, 1'b0, 1'b0);

        // err together with ack: err wins, then clear
        run_word(8'h77, 15'b110, 10'b0, 1'b0, 1'b0);
        fault_clr = 1'b1;
        @(negedge clk);
        fault_clr = 1'b0;
        exp_fault = 1'b0; exp_code = 2'd0;
        check_fault();

        // silent device
        s_valid = 1'b1; s_data = 8'hC3;
        @(negedge clk);
        s_valid = 1'b0;
        n = 0;
`ifdef WB_TIMEOUT_EN
        while (cyc && n < 40) begin
            check("silent_dat", dat_o, 8'hC3);
            n++;
            @(negedge clk);
        end
        check("timeout_cycles", n, TMO);
        exp_fault = 1'b1; exp_code = 2'd3;
        check_fault();
`else
        repeat (100) @(negedge clk);
        check("no_timeout_cyc", cyc, 1);
        check("no_timeout_dat", dat_o, 8'hC3);
        ack = 1'b1;
        @(negedge clk);
        ack = 1'b0;
        check("late_ack_cyc", cyc, 0);
        check_fault();
`endif

        // reset in the middle of REQ
        s_valid = 1'b1; s_data = 8'h99;
        @(negedge clk);
        s_valid = 1'b0;
        check("pre_rst_cyc", cyc, 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cyc", cyc, 0);
        check("async_rst_stb", stb, 0);
        @(negedge clk);
        rst = 1'b0;
        exp_fault = 1'b0; exp_code = 2'd0;
        @(negedge clk);
        check("post_rst_ready", s_ready, 1);
        check_fault();
        run_word(8'h42, 15'b010, 10'b01, 1'b0, 1'b0);

        // randomized traffic
        for (int k = 0; k < 60; k++) begin
            rp = '0;
            for (int a = 0; a < 5; a++) rp[3*a +: 3] = 3'($urandom_range(1, 7));
            wp = 10'($urandom);
            run_word(DW'($urandom), rp, wp, ($urandom_range(0, 3) == 0), 1'b1);
            if ($urandom_range(0, 2) == 0) @(negedge clk);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
